// File: rtl/dense_fc_ctrl.sv
// dense_fc_ctrl: sequencer for a dense (fully connected) layer.
// It shares the single-port weight RAM between a host loader (IDLE only) and
// the compute walk. It streams row-major weights together with activations and
// accumulates signed products. It emits one sum per output neuron over valid/ready.
module dense_fc_ctrl #(
  parameter int DEPTH     = 256,
  parameter int WIDTH     = 8,
  parameter int IN_MAX    = 64,
  parameter int OUT_MAX   = 16,
  parameter int ACC_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [$clog2(IN_MAX+1)-1:0]   num_in,
  input  logic [$clog2(OUT_MAX+1)-1:0]  num_out,
  input  logic [$clog2(DEPTH)-1:0]      w_base,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [$clog2(DEPTH)-1:0]      ld_addr,
  input  logic [WIDTH-1:0]              ld_data,
  output logic [$clog2(DEPTH)-1:0]      ram_addr,
  output logic                          ram_write_enable,
  output logic                          ram_read_enable,
  output logic [WIDTH-1:0]              ram_data_in,
  input  logic [WIDTH-1:0]              ram_data_out,
  output logic                          act_rd_en,
  output logic [$clog2(IN_MAX)-1:0]     act_rd_addr,
  input  logic [WIDTH-1:0]              act_rd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_WIDTH-1:0]          out_data,
  output logic [$clog2(OUT_MAX)-1:0]    out_idx,
  output logic                          busy,
  output logic                          done
);

  localparam int AW  = $clog2(DEPTH);
  localparam int NIW = $clog2(IN_MAX + 1);
  localparam int NOW = $clog2(OUT_MAX + 1);
  localparam int IAW = $clog2(IN_MAX);
  localparam int OIW = $clog2(OUT_MAX);
  localparam int PW  = 2 * WIDTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state_reg, state_next;
  logic [NIW-1:0]        num_in_reg;
  logic [NOW-1:0]        num_out_reg;
  logic [NIW-1:0]        i_reg;
  logic [NOW-1:0]        o_reg;
  logic [AW-1:0]         addr_reg;
  logic [ACC_WIDTH-1:0]  acc_reg;
  logic                  rd_valid_reg;

  logic                  last_in;
  logic                  last_out;
  logic [PW-1:0]         w_ext;
  logic [PW-1:0]         a_ext;
  logic [PW-1:0]         prod;
  logic [ACC_WIDTH-1:0]  prod_ext;

  // Rows are contiguous, so a running address reproduces base + o*num_in + i.
  assign last_in  = (i_reg == num_in_reg - NIW'(1));
  assign last_out = (o_reg == num_out_reg - NOW'(1));

  // Signed WIDTH x WIDTH product. The low PW bits of the product of
  // sign-extended operands are exact. The product is then widened to the accumulator.
  assign w_ext    = {{WIDTH{ram_data_out[WIDTH-1]}}, ram_data_out};
  assign a_ext    = {{WIDTH{act_rd_data[WIDTH-1]}}, act_rd_data};
  assign prod     = w_ext * a_ext;
  assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};

  // State register; reset aborts any layer in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and output decode. All outputs are forced low while reset is asserted.
  always_comb begin
    state_next       = state_reg;
    ld_ready         = 1'b0;
    ram_addr         = '0;
    ram_write_enable = 1'b0;
    ram_read_enable  = 1'b0;
    ram_data_in      = '0;
    act_rd_en        = 1'b0;
    act_rd_addr      = '0;
    out_valid        = 1'b0;
    out_data         = '0;
    out_idx          = '0;
    busy             = 1'b0;
    done             = 1'b0;
    if (reset) begin
      busy = (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (num_out == '0)     state_next = DONE;
            else if (num_in == '0) state_next = EMIT;
            else                   state_next = READ;
          end else begin
            ld_ready = 1'b1;
            if (ld_valid) begin
              ram_write_enable = 1'b1;
              ram_addr         = ld_addr;
              ram_data_in      = ld_data;
            end
          end
        end
        READ: begin
          ram_read_enable = 1'b1;
          act_rd_en       = 1'b1;
          ram_addr        = addr_reg;
          act_rd_addr     = i_reg[IAW-1:0];
          if (last_in) state_next = DRAIN;
        end
        DRAIN: begin
          state_next = EMIT;
        end
        EMIT: begin
          out_valid = 1'b1;
          out_data  = acc_reg;
          out_idx   = o_reg[OIW-1:0];
          if (out_ready) begin
            if (last_out)               state_next = DONE;
            else if (num_in_reg == '0)  state_next = EMIT;
            else                        state_next = READ;
          end
        end
        DONE: begin
          done       = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath: parameter capture, index/address counters, delayed-valid accumulate.
  always_ff @(posedge clk) begin
    if (!reset) begin
      num_in_reg   <= '0;
      num_out_reg  <= '0;
      i_reg        <= '0;
      o_reg        <= '0;
      addr_reg     <= '0;
      acc_reg      <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= (state_reg == READ);
      if (rd_valid_reg) acc_reg <= acc_reg + prod_ext;
      case (state_reg)
        IDLE: begin
          if (start) begin
            num_in_reg  <= num_in;
            num_out_reg <= num_out;
            addr_reg    <= w_base;
            i_reg       <= '0;
            o_reg       <= '0;
            acc_reg     <= '0;
          end
        end
        READ: begin
          i_reg    <= i_reg + NIW'(1);
          addr_reg <= (addr_reg == AW'(DEPTH - 1)) ? '0 : addr_reg + AW'(1);
        end
        EMIT: begin
          if (out_ready && !last_out) begin
            o_reg   <= o_reg + NOW'(1);
            i_reg   <= '0;
            acc_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_fc_ctrl.sv
// tb_dense_fc_ctrl: directed table-driven bench for dense_fc_ctrl with
// behavioural weight RAM and activation buffer (both 1-cycle registered read).
module tb_dense_fc_ctrl;
  localparam int DEPTH = 256;
  localparam int IN_MAX = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  num_in = '0;
  logic [4:0]  num_out = '0;
  logic [7:0]  w_base = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [7:0]  ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic [7:0]  ram_addr;
  logic        ram_write_enable;
  logic        ram_read_enable;
  logic [7:0]  ram_data_in;
  logic [7:0]  ram_data_out;
  logic        act_rd_en;
  logic [5:0]  act_rd_addr;
  logic [7:0]  act_rd_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] ram_mem [DEPTH] = '{default: 8'h00};
  logic [7:0] act_mem [IN_MAX];

  dense_fc_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .num_in(num_in), .num_out(num_out),
    .w_base(w_base), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ram_addr(ram_addr), .ram_write_enable(ram_write_enable),
    .ram_read_enable(ram_read_enable), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr),
    .act_rd_data(act_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Weight RAM and activation buffer models.
  always @(posedge clk) begin
    if (ram_write_enable) ram_mem[ram_addr] <= ram_data_in;
    if (ram_read_enable)  ram_data_out <= ram_mem[ram_addr];
    if (act_rd_en)        act_rd_data <= act_mem[act_rd_addr];
  end

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       exp_ready;
    logic       exp_we;
  } load_vec_t;

  typedef struct {
    int base;
    int nin;
    int nout;
    int stall;
    int exp0;
    int exp1;
  } layer_vec_t;

  load_vec_t  lv [10];
  layer_vec_t yv [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name,
               $signed(act), act, $signed(exp), exp);
    end
  endtask

  // Runs one layer from IDLE, checking every cycle at its expected position.
  task automatic run_layer(input int base, input int nin, input int nout,
                           input int stall, input int exp0, input int exp1);
    int expv;
    w_base = 8'(base); num_in = 7'(nin); num_out = 5'(nout);
    start = 1'b1; out_ready = 1'b1;
    #1;
    check("start_ld_ready", 32'(ld_ready), 0);
    check("start_we", 32'(ram_write_enable), 0);
    check("start_busy", 32'(busy), 0);
    tick();
    start = 1'b0;
    if (nout == 0) begin
      #1;
      check("empty_done", 32'(done), 1);
      check("empty_out_valid", 32'(out_valid), 0);
      tick();
    end else begin
      for (int k = 0; k < nout; k++) begin
        expv = (k == 0) ? exp0 : exp1;
        for (int j = 0; j < nin; j++) begin
          #1;
          check("read_en", 32'(ram_read_enable), 1);
          check("read_addr", 32'(ram_addr), 32'((base + k * nin + j) % DEPTH));
          check("act_addr", 32'(act_rd_addr), 32'(j));
          check("read_ld_ready", 32'(ld_ready), 0);
          check("read_we", 32'(ram_write_enable), 0);
          check("read_out_valid", 32'(out_valid), 0);
          tick();
        end
        if (nin > 0) begin
          #1;
          check("drain_valid", 32'(out_valid), 0);
          check("drain_read_en", 32'(ram_read_enable), 0);
          check("drain_busy", 32'(busy), 1);
          tick();
        end
        if (k == 0 && stall > 0) begin
          out_ready = 1'b0;
          for (int s = 0; s < stall; s++) begin
            #1;
            check("stall_valid", 32'(out_valid), 1);
            check("stall_data", out_data, 32'(expv));
            check("stall_idx", 32'(out_idx), 32'(k));
            check("stall_read_en", 32'(ram_read_enable), 0);
            tick();
          end
          out_ready = 1'b1;
        end
        #1;
        check("emit_valid", 32'(out_valid), 1);
        check("emit_data", out_data, 32'(expv));
        check("emit_idx", 32'(out_idx), 32'(k));
        check("emit_we", 32'(ram_write_enable), 0);
        check("emit_ld_ready", 32'(ld_ready), 0);
        $display("layer base=%0d nin=%0d: neuron %0d -> %0d", base, nin, out_idx, $signed(out_data));
        tick();
      end
      #1;
      check("done_pulse", 32'(done), 1);
      check("done_out_valid", 32'(out_valid), 0);
      tick();
    end
    #1;
    check("idle_busy", 32'(busy), 0);
    check("idle_done", 32'(done), 0);
  endtask

  initial begin
    act_mem = '{default: 8'h00};
    act_mem[0] = 8'd10; act_mem[1] = 8'd20; act_mem[2] = 8'd30; act_mem[3] = 8'd40;

    lv[0] = '{8'd0,   8'd1,  1'b1, 1'b1};
    lv[1] = '{8'd1,   8'd2,  1'b1, 1'b1};
    lv[2] = '{8'd2,   8'd3,  1'b1, 1'b1};
    lv[3] = '{8'd3,   8'd4,  1'b1, 1'b1};
    lv[4] = '{8'd4,   8'hFF, 1'b1, 1'b1};
    lv[5] = '{8'd5,   8'hFF, 1'b1, 1'b1};
    lv[6] = '{8'd6,   8'hFF, 1'b1, 1'b1};
    lv[7] = '{8'd7,   8'hFF, 1'b1, 1'b1};
    lv[8] = '{8'd254, 8'd5,  1'b1, 1'b1};
    lv[9] = '{8'd255, 8'd6,  1'b1, 1'b1};

    yv[0] = '{0,   4, 2, 0, 300, -100};
    yv[1] = '{0,   4, 2, 5, 300, -100};
    yv[2] = '{0,   2, 2, 0, 50,  110};
    yv[3] = '{2,   3, 2, 0, 80,  -60};
    yv[4] = '{254, 4, 1, 0, 280, 0};
    yv[5] = '{0,   0, 2, 0, 0,   0};
    yv[6] = '{0,   4, 0, 0, 0,   0};
    yv[7] = '{1,   1, 2, 0, 20,  30};

    // Reset state.
    reset = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_read_en", 32'(ram_read_enable), 0);
    check("rst_we", 32'(ram_write_enable), 0);
    check("rst_act_en", 32'(act_rd_en), 0);
    check("rst_out_data", out_data, 0);
    reset = 1'b1;
    tick();
    check("idle_ld_ready", 32'(ld_ready), 1);

    // Loader writes from the table.
    for (int k = 0; k < 10; k++) begin
      ld_valid = 1'b1; ld_addr = lv[k].addr; ld_data = lv[k].data;
      #1;
      check("load_ready", 32'(ld_ready), 32'(lv[k].exp_ready));
      check("load_we", 32'(ram_write_enable), 32'(lv[k].exp_we));
      check("load_addr", 32'(ram_addr), 32'(lv[k].addr));
      check("load_data", 32'(ram_data_in), 32'(lv[k].data));
      $display("load addr=%0d data=%0d", lv[k].addr, $signed(lv[k].data));
      tick();
    end
    ld_valid = 1'b0;
    for (int k = 0; k < 10; k++) check("load_readback", 32'(ram_mem[lv[k].addr]), 32'(lv[k].data));

    // Layer runs from the table.
    for (int k = 0; k < 8; k++)
      run_layer(yv[k].base, yv[k].nin, yv[k].nout, yv[k].stall, yv[k].exp0, yv[k].exp1);

    // Loader held during a whole layer: blocked until the first IDLE cycle.
    ld_valid = 1'b1; ld_addr = 8'd100; ld_data = 8'd77;
    run_layer(0, 4, 2, 0, 300, -100);
    check("arb_no_early_write", 32'(ram_mem[100]), 0);
    check("arb_idle_ready", 32'(ld_ready), 1);
    check("arb_idle_we", 32'(ram_write_enable), 1);
    check("arb_idle_addr", 32'(ram_addr), 100);
    tick();
    ld_valid = 1'b0;
    check("arb_written", 32'(ram_mem[100]), 77);

    // Reset asserted in the middle of READ.
    w_base = 8'd0; num_in = 7'd4; num_out = 5'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mid_read_en", 32'(ram_read_enable), 1);
    reset = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 0);
    check("abort_read_en", 32'(ram_read_enable), 0);
    check("abort_act_en", 32'(act_rd_en), 0);
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_done", 32'(done), 0);
    check("abort_ld_ready", 32'(ld_ready), 0);
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      check("post_abort_done", 32'(done), 0);
      check("post_abort_valid", 32'(out_valid), 0);
      check("post_abort_busy", 32'(busy), 0);
    end
    $display("reset abort sequence complete");

    // Most negative operands: -128 * -128 summed four times.
    for (int k = 0; k < 4; k++) act_mem[k] = 8'h80;
    for (int k = 0; k < 4; k++) begin
      ld_valid = 1'b1; ld_addr = 8'(16 + k); ld_data = 8'h80;
      tick();
    end
    ld_valid = 1'b0;
    run_layer(16, 4, 1, 0, 65536, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
